fp_square: RTL and testbench
============================

Name: fp_square

Overview:
- Iterative IEEE-754 squarer: computes x*x from unpacked sign/exponent/fraction fields and returns unpacked result fields.
- Inverse companion of the FP square-root unit. Used to check sqrt results (sqrt(x)^2 ≈ x) and as a standalone datapath op.
- Mantissa product is built by a shift-add sub-module, one multiplier bit per cycle.
- Fixed latency regardless of operand value.

Parameters:
- EXP_WIDTH, 11, exponent field width.
- FRAC_WIDTH, 52, stored fraction width (hidden bit excluded).
- BIAS, 1023, exponent bias.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  accept operand when idle
- i_sign  in  1  operand sign (ignored for result)
- i_exp  in  EXP_WIDTH  operand biased exponent
- i_frac  in  FRAC_WIDTH  operand fraction
- busy  out  1  high from accept until ready cycle inclusive
- ready  out  1  one-cycle pulse, result valid
- o_sign  out  1  result sign, always 0
- o_exp  out  EXP_WIDTH  result biased exponent
- o_frac  out  FRAC_WIDTH  result fraction
- o_overflow  out  1  result saturated to +inf
- o_underflow  out  1  result flushed to +0

Behaviour:
- Clock, reset: reset is synchronous, active-high; clock is clk.
- Reset values: all outputs 0; state IDLE.
- Reset mid-operation: aborts the operation; the next cycle is IDLE with outputs 0 and no ready pulse.
- States:
  - IDLE: start=1 latches the operands, sets busy, goes to CALC.
  - CALC: runs FRAC_WIDTH+1 cycles. Multiplier M={1,i_frac} times M; product P is 2*FRAC_WIDTH+2 bits.
  - NORM: 1 cycle of normalise, exponent, specials.
  - DONE: ready=1 for one cycle, then IDLE.
- Latency: start sampled in cycle 0; ready high in cycle FRAC_WIDTH+3 (55 for the defaults).
- Outputs hold their value after ready until the next accept or reset.
- start while busy: ignored. start in the DONE cycle: ignored.
- Normalisation:
  - n = P[MSB].
  - If n=1: frac = P[MSB-1 -: FRAC_WIDTH], else frac = P[MSB-2 -: FRAC_WIDTH].
- Exponent: computed signed in EXP_WIDTH+2 bits as e = 2*i_exp - BIAS + n.
- Specials, checked in this order:
  - i_exp=all-ones (inf/NaN): o_exp=all-ones, o_frac=i_frac (NaN payload kept, inf stays inf), flags 0.
  - i_exp=0 (zero/denormal flushed): o_exp=0, o_frac=0, flags 0.
  - e >= 2^EXP_WIDTH-1: o_exp=all-ones, o_frac=0, o_overflow=1.
  - e <= 0: o_exp=0, o_frac=0, o_underflow=1.
- Specials still take the full latency.
- o_sign is always 0, including for NaN.

Optional Feature:
- Macro FP_SQUARE_ROUND_EN.
- Defined: round-to-nearest-even on the discarded product bits (guard, sticky, LSB).
  - A rounding carry out of the fraction sets frac=0 and e+1.
  - Overflow is checked after rounding.
  - Rounding happens in NORM; latency is unchanged.
- Undefined: truncation.

Decomposition:
- Package fp_pkg holds:
  - EXP_WIDTH, FRAC_WIDTH, BIAS.
  - EXP_ALL_ONES constant.
  - State encoding (IDLE, CALC, NORM, DONE).
  - A mantissa-product width constant.
- Sub-module mantissa_mul_seq: unsigned shift-add multiplier.
  - Ports: clk, reset, load, a, b, done, p.
  - Latency: FRAC_WIDTH+1 cycles.
  - fp_square owns the FSM and NORM logic.

Test Plan:
- 2.0 (exp 1024, frac 0), start pulse: ready at cycle 55 with exp 1025, frac 0, flags 0. busy high for cycles 0..55.
- 1.5 (exp 1023, frac 0x8000000000000): exp 1024, frac 0x2000000000000 (2.25).
- -3.0 (sign 1, exp 1024, frac 0x8000000000000): sign 0, exp 1026, frac 0x2000000000000 (9.0).
- Boundaries:
  - exp 2046 → exp 2047, frac 0, o_overflow=1.
  - exp 1 → exp 0, frac 0, o_underflow=1.
  - exp 2047, frac 0x1 → exp 2047, frac 0x1.
  - exp 0 → all 0.
- Rounding, exp 1023, frac 0x0000005000000:
  - Without macro: frac 0x000000A000001.
  - With FP_SQUARE_ROUND_EN: frac 0x000000A000002.
  - exp 1023 in both cases.
- Control:
  - start re-asserted at cycle 10: ignored, single ready at cycle 55.
  - reset at cycle 20: outputs 0, no ready.
  - New start after reset: correct result 55 cycles later.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the FP squarer and its
// shift-add mantissa multiplier.
package fp_pkg;
  localparam int EXP_WIDTH  = 11;
  localparam int FRAC_WIDTH = 52;
  localparam int BIAS       = 1023;

  localparam logic [EXP_WIDTH-1:0] EXP_ALL_ONES = '1;
  localparam int EXP_MAX = 2**EXP_WIDTH - 1;

  localparam int MANT_W = FRAC_WIDTH + 1;
  localparam int PROD_W = 2 * MANT_W;
  localparam int CNT_W  = $clog2(MANT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/mantissa_mul_seq.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, MANT_W
// iterations after the load cycle, done held until the next load.
module mantissa_mul_seq
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic              done,
  output logic [PROD_W-1:0] p
);
  logic [PROD_W-1:0] mcand;
  logic [MANT_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              run;

  always_ff @(posedge clk) begin
    if (reset) begin
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done   <= 1'b0;
    end else if (load) begin
      p      <= '0;
      mcand  <= {{MANT_W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      run    <= 1'b1;
      done   <= 1'b0;
    end else if (run) begin
      if (mplier[0]) p <= p + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_W'(MANT_W - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_square.sv
// Iterative IEEE-754 squarer on unpacked fields, fixed latency.
// Define FP_SQUARE_ROUND_EN for round-to-nearest-even; default truncates.
module fp_square
  import fp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  i_sign,
  input  logic [EXP_WIDTH-1:0]  i_exp,
  input  logic [FRAC_WIDTH-1:0] i_frac,
  output logic                  busy,
  output logic                  ready,
  output logic                  o_sign,
  output logic [EXP_WIDTH-1:0]  o_exp,
  output logic [FRAC_WIDTH-1:0] o_frac,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  state_t                state;
  logic [EXP_WIDTH-1:0]  exp_q;
  logic [FRAC_WIDTH-1:0] frac_q;
  logic                  load, mul_done;
  logic [PROD_W-1:0]     prod, norm_p;
  logic                  n;
  logic [FRAC_WIDTH-1:0] frac_t, frac_r;
  logic [EXP_WIDTH+1:0]  e, e_r;
  logic                  ovf, unf;
  logic                  sign_unused, tail_unused;

  assign sign_unused = i_sign;
  assign load        = (state == IDLE) && start;

  // Operand is fed straight from the ports so the multiplier starts in the accept cycle
  mantissa_mul_seq u_mul (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .a     ({1'b1, i_frac}),
    .b     ({1'b1, i_frac}),
    .done  (mul_done),
    .p     (prod)
  );

  assign n      = prod[PROD_W-1];
  assign norm_p = n ? prod : prod << 1;
  assign frac_t = norm_p[PROD_W-2 -: FRAC_WIDTH];
  assign e      = {1'b0, exp_q, 1'b0} - (EXP_WIDTH+2)'(BIAS) + {{(EXP_WIDTH+1){1'b0}}, n};

`ifdef FP_SQUARE_ROUND_EN
  logic guard, sticky, carry;
  assign guard       = norm_p[PROD_W-2-FRAC_WIDTH];
  assign sticky      = |norm_p[PROD_W-3-FRAC_WIDTH:0];
  assign {carry, frac_r} = {1'b0, frac_t} + (FRAC_WIDTH+1)'(guard & (sticky | frac_t[0]));
  assign e_r         = e + {{(EXP_WIDTH+1){1'b0}}, carry};
  assign tail_unused = norm_p[PROD_W-1];
`else
  assign frac_r      = frac_t;
  assign e_r         = e;
  assign tail_unused = ^{norm_p[PROD_W-1], norm_p[PROD_W-2-FRAC_WIDTH:0]};
`endif

  // e_r is two's complement; the top bit flags a negative exponent
  assign ovf = !e_r[EXP_WIDTH+1] && (e_r[EXP_WIDTH:0] >= (EXP_WIDTH+1)'(EXP_MAX));
  assign unf = e_r[EXP_WIDTH+1] || (e_r == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      exp_q       <= '0;
      frac_q      <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      o_sign      <= 1'b0;
      o_exp       <= '0;
      o_frac      <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          exp_q  <= i_exp;
          frac_q <= i_frac;
          busy   <= 1'b1;
          state  <= CALC;
        end
        CALC: if (mul_done) state <= NORM;
        NORM: begin
          o_sign      <= 1'b0;
          o_overflow  <= 1'b0;
          o_underflow <= 1'b0;
          if (exp_q == EXP_ALL_ONES) begin
            o_exp  <= EXP_ALL_ONES;
            o_frac <= frac_q;
          end else if (exp_q == '0) begin
            o_exp  <= '0;
            o_frac <= '0;
          end else if (ovf) begin
            o_exp      <= EXP_ALL_ONES;
            o_frac     <= '0;
            o_overflow <= 1'b1;
          end else if (unf) begin
            o_exp       <= '0;
            o_frac      <= '0;
            o_underflow <= 1'b1;
          end else begin
            o_exp  <= e_r[EXP_WIDTH-1:0];
            o_frac <= frac_r;
          end
          ready <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_square.sv
// Directed bench for fp_square: results, specials, latency, restart and abort.
module tb_fp_square;
  import fp_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset, start, i_sign;
  logic [EXP_WIDTH-1:0]  i_exp;
  logic [FRAC_WIDTH-1:0] i_frac;
  logic                  busy, ready, o_sign, o_overflow, o_underflow;
  logic [EXP_WIDTH-1:0]  o_exp;
  logic [FRAC_WIDTH-1:0] o_frac;

  int n_assert = 0;
  int n_fail   = 0;
  int lat, cnt;

  always #5 clk = ~clk;

  fp_square dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .i_sign      (i_sign),
    .i_exp       (i_exp),
    .i_frac      (i_frac),
    .busy        (busy),
    .ready       (ready),
    .o_sign      (o_sign),
    .o_exp       (o_exp),
    .o_frac      (o_frac),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pulses start for one cycle; returns at the negedge of cycle 0 (first busy cycle)
  task automatic launch(input logic s, input logic [EXP_WIDTH-1:0] e, input logic [FRAC_WIDTH-1:0] f);
    @(negedge clk);
    i_sign = s; i_exp = e; i_frac = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input int from, output int cyc);
    cyc = from;
    while (!ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [EXP_WIDTH-1:0] e,
                              input logic [FRAC_WIDTH-1:0] f, input logic ov, input logic un);
    check({tag, " sign"}, 64'(o_sign), 64'd0);
    check({tag, " exp"}, 64'(o_exp), 64'(e));
    check({tag, " frac"}, 64'(o_frac), 64'(f));
    check({tag, " ovf"}, 64'(o_overflow), 64'(ov));
    check({tag, " unf"}, 64'(o_underflow), 64'(un));
  endtask

  task automatic run(input string tag, input logic s, input logic [EXP_WIDTH-1:0] e_in,
                     input logic [FRAC_WIDTH-1:0] f_in, input logic [EXP_WIDTH-1:0] e,
                     input logic [FRAC_WIDTH-1:0] f, input logic ov, input logic un);
    int l;
    launch(s, e_in, f_in);
    check({tag, " busy c0"}, 64'(busy), 64'd1);
    wait_ready(0, l);
    check({tag, " latency"}, 64'(l), 64'd55);
    check({tag, " busy rdy"}, 64'(busy), 64'd1);
    check_result(tag, e, f, ov, un);
    @(negedge clk);
    check({tag, " ready pulse"}, 64'(ready), 64'd0);
    check({tag, " busy after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; i_sign = 1'b0; i_exp = '0; i_frac = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check_result("reset", '0, '0, 1'b0, 1'b0);
    reset = 1'b0;

    run("2.0",  1'b0, 11'd1024, 52'h0, 11'd1025, 52'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("hold exp", 64'(o_exp), 64'd1025);
    run("1.5",  1'b0, 11'd1023, 52'h8000000000000, 11'd1024, 52'h2000000000000, 1'b0, 1'b0);
    run("-3.0", 1'b1, 11'd1024, 52'h8000000000000, 11'd1026, 52'h2000000000000, 1'b0, 1'b0);
    run("ovf",  1'b0, 11'd2046, 52'h0, 11'd2047, 52'h0, 1'b1, 1'b0);
    run("unf",  1'b0, 11'd1,    52'h0, 11'd0,    52'h0, 1'b0, 1'b1);
    run("nan",  1'b1, 11'd2047, 52'h1, 11'd2047, 52'h1, 1'b0, 1'b0);
    run("zero", 1'b1, 11'd0,    52'h123, 11'd0,  52'h0, 1'b0, 1'b0);
`ifdef FP_SQUARE_ROUND_EN
    run("round", 1'b0, 11'd1023, 52'h0000005000000, 11'd1023, 52'h000000A000002, 1'b0, 1'b0);
`else
    run("trunc", 1'b0, 11'd1023, 52'h0000005000000, 11'd1023, 52'h000000A000001, 1'b0, 1'b0);
`endif

    // start re-asserted mid-operation with different operands must be ignored
    launch(1'b0, 11'd1024, 52'h0);
    repeat (10) @(negedge clk);
    i_exp = 11'd1023; i_frac = 52'h8000000000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(11, lat);
    check("restart latency", 64'(lat), 64'd55);
    check_result("restart", 11'd1025, 52'h0, 1'b0, 1'b0);
    cnt = 0;
    repeat (70) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    check("restart extra ready", 64'(cnt), 64'd0);

    // Reset at cycle 20 aborts the operation
    launch(1'b0, 11'd1023, 52'h8000000000000);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort ready", 64'(ready), 64'd0);
    check_result("abort", '0, '0, 1'b0, 1'b0);
    cnt = 0;
    repeat (70) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    check("abort no ready", 64'(cnt), 64'd0);

    run("post-abort", 1'b1, 11'd1024, 52'h8000000000000, 11'd1026, 52'h2000000000000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
